// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - size encodings, FSM states and IO window constant shared by mem_ctrl
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Writes into this address window go to the UART and honour io_buffer_full.
  localparam logic [1:0] IO_ADDR_SEL = 2'b11;
  localparam int         IO_ADDR_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [2:0] xfer_len(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_rdata(input logic [31:0] raw, input logic [1:0] size,
                                               input logic sgn);
    case (size)
      SZ_BYTE: return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      SZ_HALF: return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - mem_arb channel arbiter; round-robin with MEM_CTRL_RR_EN, fixed priority otherwise
module mem_arb #(
  parameter int NUM_CH = 2,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     gnt_idx,
  output logic              gnt_any
);

  int best;

`ifdef MEM_CTRL_RR_EN
  logic [IW-1:0] ptr;
  int            best_rank;
  int            rank;

  // Rank each channel by its distance from the pointer; the closest requester wins.
  always_comb begin
    best      = 0;
    best_rank = NUM_CH;
    rank      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rank = (i >= int'(ptr)) ? i - int'(ptr) : i + NUM_CH - int'(ptr);
      if (req[i] && rank < best_rank) begin
        best_rank = rank;
        best      = i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= '0;
    else if (advance && gnt_any)
      ptr <= (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, rst, advance};

  always_comb begin
    best = 0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) best = i;
  end
`endif

  always_comb begin
    gnt_any = |req;
    gnt_idx = IW'(best);
    gnt     = '0;
    for (int i = 0; i < NUM_CH; i++)
      gnt[i] = gnt_any && (best == i);
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial multi-channel memory controller; MEM_CTRL_RR_EN selects round-robin arbitration
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy_in,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_signed,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]        flush,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_rdata,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   req_mask, gnt;
  logic [IW-1:0]       gnt_idx, ch_q;
  logic                gnt_any;
  logic                sel_we, sel_signed;
  logic [1:0]          sel_size, size_q;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata, wdata_q, rbuf, rd_word;
  logic                signed_q;
  logic [2:0]          len_q, cnt_q;
  logic [1:0]          cap_idx, nxt_idx;
  logic                flush_hit, io_block, last_rd, last_wr;

  // A channel receiving its response this cycle may not be re-granted immediately.
  assign req_mask = req_valid & ~resp_valid;

  mem_arb #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .advance (rdy_in && (state == IDLE)),
    .req     (req_mask),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_we     = 1'b0;
    sel_signed = 1'b0;
    sel_size   = SZ_BYTE;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_we     = req_we[i];
        sel_signed = req_signed[i];
        sel_size   = req_size[2*i +: 2];
        sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata  = req_wdata[32*i +: 32];
      end
    end
  end

  assign flush_hit = (state == READ) && flush[ch_q];
  assign io_block  = (state == WRITE) && io_buffer_full &&
                     (mem_a[IO_ADDR_LSB +: 2] == IO_ADDR_SEL);
  assign last_rd   = (cnt_q == len_q);
  assign last_wr   = (cnt_q == len_q - 3'd1);
  assign cap_idx   = 2'(cnt_q - 3'd1);
  assign nxt_idx   = 2'(cnt_q + 3'd1);

  // Byte returned this cycle belongs to the address issued one cycle earlier.
  always_comb begin
    rd_word = rbuf;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rdy_in) begin
      case (state)
        IDLE:    if (gnt_any) state_nxt = sel_we ? WRITE : READ;
        READ:    if (flush_hit || last_rd) state_nxt = IDLE;
        WRITE:   if (!io_block && last_wr) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wr = rdy_in && (state == WRITE) && !io_block;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_a      <= '0;
      mem_dout   <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      cnt_q      <= '0;
      len_q      <= 3'd1;
      ch_q       <= '0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      rbuf       <= '0;
    end else if (rdy_in) begin
      resp_valid <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          ch_q     <= gnt_idx;
          size_q   <= sel_size;
          signed_q <= sel_signed;
          wdata_q  <= sel_wdata;
          len_q    <= xfer_len(sel_size);
          cnt_q    <= '0;
          mem_a    <= sel_addr;
          mem_dout <= sel_wdata[7:0];
        end
        READ: if (!flush_hit) begin
          if (cnt_q != 3'd0) rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
          if (last_rd) begin
            resp_valid[ch_q] <= 1'b1;
            resp_rdata       <= extend_rdata(rd_word, size_q, signed_q);
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q + 3'd1 < len_q) mem_a <= mem_a + ADDR_W'(1);
          end
        end
        WRITE: if (!io_block) begin
          if (last_wr) begin
            resp_valid[ch_q] <= 1'b1;
          end else begin
            cnt_q    <= cnt_q + 3'd1;
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= wdata_q[{nxt_idx, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a transaction-level model
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic                     clk = 1'b0;
  logic                     rst, rdy_in, io_buffer_full, mem_wr;
  logic [NUM_CH-1:0]        req_valid, req_we, req_signed, flush, resp_valid;
  logic [2*NUM_CH-1:0]      req_size;
  logic [ADDR_W*NUM_CH-1:0] req_addr;
  logic [32*NUM_CH-1:0]     req_wdata;
  logic [31:0]              resp_rdata;
  logic [7:0]               mem_din, mem_dout;
  logic [ADDR_W-1:0]        mem_a;

  mem_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int                n_vec, n_miss;
  logic [7:0]        mem [logic [31:0]];
  logic [7:0]        next_din;
  logic [31:0]       obs_a, obs_rdata, last_rdata;
  logic              obs_wr;
  logic [7:0]        obs_dout;
  logic [NUM_CH-1:0] obs_resp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] size, input bit sgn);
    int n;
    logic [31:0] v;
    n = nbytes(size);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(peek(addr + 32'(i))) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Sample mid-cycle, update the byte memory, and present the read byte in the next cycle.
  task automatic tick();
    @(negedge clk);
    obs_a = mem_a; obs_wr = mem_wr; obs_dout = mem_dout;
    obs_resp = resp_valid; obs_rdata = resp_rdata;
    if (obs_wr) mem[obs_a] = obs_dout;
    next_din = peek(obs_a);
    @(posedge clk);
    #1 mem_din = next_din;
  endtask

  task automatic clear_req();
    req_valid = '0; req_we = '0; req_size = '0; req_signed = '0;
    req_addr = '0; req_wdata = '0; flush = '0;
  endtask

  task automatic txn(input string tag, input int ch, input bit we, input logic [1:0] size,
                     input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input int st_from, input int st_len, input bit st_io);
    int n, cyc, exp_resp, resp_off, limit;
    int exp_off[4];
    logic [31:0] exp_rd, ai;
    logic [31:0] a_trace[64];
    int wr_off[$];
    logic [31:0] wr_a[$];
    logic [7:0] wr_d[$];
    bit other;
    n = nbytes(size);
    exp_rd = ref_read(addr, size, sgn);
    cyc = 1;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ai = addr + 32'(i);
        while (cyc >= st_from && cyc < st_from + st_len && (!st_io || ai[17:16] == 2'b11)) cyc++;
        exp_off[i] = cyc;
        cyc++;
      end
      exp_resp = cyc;
    end else begin
      exp_resp = n + 2;
    end
    req_valid[ch] = 1'b1; req_we[ch] = we; req_size[2*ch +: 2] = size; req_signed[ch] = sgn;
    req_addr[32*ch +: 32] = addr; req_wdata[32*ch +: 32] = wdata;
    tick();
    clear_req();
    resp_off = -1; other = 0; last_rdata = '0;
    limit = exp_resp + st_len + 3;
    for (int off = 1; off <= limit; off++) begin
      rdy_in = !(!st_io && off >= st_from && off < st_from + st_len);
      io_buffer_full = st_io && off >= st_from && off < st_from + st_len;
      tick();
      if (off < 64) a_trace[off] = obs_a;
      if (obs_wr) begin wr_off.push_back(off); wr_a.push_back(obs_a); wr_d.push_back(obs_dout); end
      if (obs_resp[ch] && resp_off < 0) begin resp_off = off; last_rdata = obs_rdata; end
      if ((obs_resp & ~(NUM_CH'(1) << ch)) != '0) other = 1;
    end
    rdy_in = 1'b1; io_buffer_full = 1'b0;
    check_eq({tag, " resp_lat"}, 32'(resp_off), 32'(exp_resp));
    check_eq({tag, " other_resp"}, 32'(other), 32'd0);
    if (we) begin
      check_eq({tag, " wr_count"}, 32'(wr_off.size()), 32'(n));
      for (int i = 0; i < n && i < wr_off.size(); i++) begin
        check_eq({tag, " wr_cycle"}, 32'(wr_off[i]), 32'(exp_off[i]));
        check_eq({tag, " wr_addr"}, wr_a[i], addr + 32'(i));
        check_eq({tag, " wr_data"}, 32'(wr_d[i]), 32'(wdata[8*i +: 8]));
      end
    end else begin
      for (int i = 0; i < n; i++) check_eq({tag, " rd_addr"}, a_trace[1+i], addr + 32'(i));
      check_eq({tag, " rdata"}, last_rdata, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ch, sf, sl, seen1, resp0, got, exp_ch;
    bit we, sgn, sio, saw;
    logic [1:0] size;
    logic [31:0] addr, wdata, a4, rd0;
    n_vec = 0; n_miss = 0;
    rst = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; mem_din = '0;
    clear_req();
    repeat (3) tick();
    check_eq("rst mem_a", obs_a, 32'd0);
    check_eq("rst mem_wr", 32'(obs_wr), 32'd0);
    check_eq("rst mem_dout", 32'(obs_dout), 32'd0);
    check_eq("rst resp_valid", 32'(obs_resp), 32'd0);
    check_eq("rst resp_rdata", obs_rdata, 32'd0);
    rst = 1'b1;
    tick();

    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    txn("rd_word", 0, 0, 2'd2, 0, 32'h100, 32'h0, 0, 0, 0);
    check_eq("rd_word value", last_rdata, 32'h44332211);
    mem[32'h200] = 8'h80;
    txn("rd_sbyte", 0, 0, 2'd0, 1, 32'h200, 32'h0, 0, 0, 0);
    check_eq("rd_sbyte value", last_rdata, 32'hFFFFFF80);
    txn("rd_ubyte", 1, 0, 2'd0, 0, 32'h200, 32'h0, 0, 0, 0);
    check_eq("rd_ubyte value", last_rdata, 32'h00000080);
    txn("io_wr", 0, 1, 2'd0, 0, 32'h30000, 32'h41, 1, 3, 1);
    check_eq("io_wr mem", 32'(peek(32'h30000)), 32'h41);
    txn("rdy_wr", 1, 1, 2'd2, 0, 32'h400, 32'hA1B2C3D4, 2, 2, 0);
    txn("rd_wrap", 1, 0, 2'd2, 0, 32'hFFFFFFFE, 32'h0, 0, 0, 0);

    // flush of a ch1 half read; ch0 is granted in the very next cycle
    req_valid[1] = 1'b1; req_size[3:2] = 2'd1; req_addr[63:32] = 32'h500;
    tick(); clear_req();
    seen1 = 0;
    tick(); if (obs_resp[1]) seen1 = 1;
    flush[1] = 1'b1; tick(); flush = '0; if (obs_resp[1]) seen1 = 1;
    req_valid[0] = 1'b1; req_addr[31:0] = 32'h600;
    tick(); clear_req(); if (obs_resp[1]) seen1 = 1;
    resp0 = -1; rd0 = '0; a4 = '0;
    for (int off = 4; off <= 10; off++) begin
      tick();
      if (off == 4) a4 = obs_a;
      if (obs_resp[1]) seen1 = 1;
      if (obs_resp[0] && resp0 < 0) begin resp0 = off; rd0 = obs_rdata; end
    end
    check_eq("flush no_resp", 32'(seen1), 32'd0);
    check_eq("flush next_addr", a4, 32'h600);
    check_eq("flush next_lat", 32'(resp0), 32'd6);
    check_eq("flush next_data", rd0, 32'(peek(32'h600)));

    for (int k = 0; k < 40; k++) begin
      ch = int'($urandom_range(NUM_CH - 1, 0));
      we = 1'($urandom_range(1, 0));
      size = 2'($urandom_range(3, 0));
      sgn = 1'($urandom_range(1, 0));
      wdata = $urandom;
      case ($urandom_range(3, 0))
        0: addr = 32'hFFFFFFFF - 32'($urandom_range(2, 0));
        1, 2: addr = 32'h1000 + 32'($urandom_range(15, 0));
        default: addr = $urandom;
      endcase
      sf = 0; sl = 0; sio = 0;
      if (we && $urandom_range(1, 0) == 1) begin
        sf = int'($urandom_range(4, 1));
        sl = int'($urandom_range(3, 1));
        sio = 1'($urandom_range(1, 0));
        if (sio) addr[17:16] = 2'b11;
      end
      txn("rand", ch, we, size, sgn, addr, wdata, sf, sl, sio);
    end

    // reset in the middle of a word write abandons it silently
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[1:0] = 2'd2; req_addr[31:0] = 32'h700;
    tick(); clear_req();
    tick();
    rst = 1'b0; tick(); rst = 1'b1;
    saw = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (obs_resp != '0 || obs_wr) saw = 1;
    end
    check_eq("midrst quiet", 32'(saw), 32'd0);
    check_eq("midrst mem_a", obs_a, 32'd0);

    rst = 1'b0; tick(); rst = 1'b1; tick();
    for (int r = 0; r < 4; r++) begin
      req_valid = '1; req_addr[31:0] = 32'h800; req_addr[63:32] = 32'h900;
      tick(); clear_req();
      got = -1;
      for (int j = 0; j < 8; j++) begin
        tick();
        if (got < 0 && obs_resp[0]) got = 0;
        else if (got < 0 && obs_resp[1]) got = 1;
      end
`ifdef MEM_CTRL_RR_EN
      exp_ch = r % 2;
`else
      exp_ch = 0;
`endif
      check_eq("arb grant", 32'(got), 32'(exp_ch));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
